// File: rtl/sha_msg_loader.sv
// SHA-256 message RAM writer: streams message bytes into a byte-wide RAM
// port at sequential addresses, then appends 0x80, zero fill and the 64-bit
// big-endian bit length, and reports the resulting 512-bit block count.
module sha_msg_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MAX_LEN = 1015
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              empty_msg,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [4:0]        num_blocks,
  output logic [ADDR_W-1:0] msg_bytes
);

  // One extra bit so the padded size P (up to 2**ADDR_W) is representable.
  localparam int unsigned PW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD80,
    S_PADZ,
    S_PADLEN,
    S_DROP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [3:0]        pidx_q, pidx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        nblk_q, nblk_d;
  logic [ADDR_W-1:0] mbytes_q, mbytes_d;

  logic [PW-1:0]     len_p8;
  logic [PW-1:0]     nblk_w;
  logic [PW-1:0]     pad_end;
  logic [PW-1:0]     zlast;
  logic [63:0]       bitlen;
  logic [5:0]        len_shift;
  logic [7:0]        len_byte;

  // Padding geometry derived from the latched message length.
  always_comb begin
    len_p8    = PW'(len_q) + PW'(8);
    nblk_w    = (len_p8 >> 6) + PW'(1);
    pad_end   = nblk_w << 6;
    zlast     = pad_end - PW'(9);
    bitlen    = 64'({len_q, 3'b000});
    len_shift = {3'd7 - pidx_q[2:0], 3'b000};
    len_byte  = 8'(bitlen >> len_shift);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    pidx_d   = pidx_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ovf_d    = ovf_q;
    nblk_d   = nblk_q;
    mbytes_d = mbytes_q;
    in_ready = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d  = '0;
          len_d    = '0;
          pidx_d   = '0;
          ovf_d    = 1'b0;
          nblk_d   = '0;
          mbytes_d = '0;
          state_d  = empty_msg ? S_PAD80 : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count_q == ADDR_W'(MAX_LEN)) begin
            ovf_d   = 1'b1;
            state_d = in_last ? S_DONE : S_DROP;
          end else begin
            we_d    = 1'b1;
            waddr_d = count_q;
            wdata_d = in_data;
            count_d = count_q + 1'b1;
            if (in_last) begin
              len_d   = count_q + 1'b1;
              state_d = S_PAD80;
            end
          end
        end
      end
      S_PAD80: begin
        we_d    = 1'b1;
        waddr_d = count_q;
        wdata_d = 8'h80;
        count_d = count_q + 1'b1;
        state_d = (len_q[5:0] == 6'd55) ? S_PADLEN : S_PADZ;
      end
      S_PADZ: begin
        we_d    = 1'b1;
        waddr_d = count_q;
        wdata_d = 8'h00;
        count_d = count_q + 1'b1;
        if (PW'(count_q) == zlast) state_d = S_PADLEN;
      end
      S_PADLEN: begin
        // Eight length writes, then one idle cycle so done rises the cycle
        // after the final write is presented. The address is not advanced
        // past the last byte so it never wraps at full capacity.
        if (!pidx_q[3]) begin
          we_d    = 1'b1;
          waddr_d = count_q;
          wdata_d = len_byte;
          pidx_d  = pidx_q + 1'b1;
          if (pidx_q != 4'd7) count_d = count_q + 1'b1;
        end else begin
          nblk_d   = 5'(nblk_w);
          mbytes_d = len_q;
          state_d  = S_DONE;
        end
      end
      S_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      len_q    <= '0;
      pidx_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
      nblk_q   <= '0;
      mbytes_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      pidx_q   <= pidx_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
      nblk_q   <= nblk_d;
      mbytes_q <= mbytes_d;
    end
  end

  // Status decode from the state register.
  always_comb begin
    busy = (state_q == S_LOAD) || (state_q == S_PAD80) || (state_q == S_PADZ) ||
           (state_q == S_PADLEN) || (state_q == S_DROP);
    done = (state_q == S_DONE);
  end

  assign ram_we     = we_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign overflow   = ovf_q;
  assign num_blocks = nblk_q;
  assign msg_bytes  = mbytes_q;

endmodule

// File: tb/tb_sha_msg_loader.sv
// Bench for sha_msg_loader: table of messages, expected RAM writes queued by
// a reference padding model and popped as the DUT writes, plus reset cases.
module tb_sha_msg_loader;

  localparam int ADDR_W  = 10;
  localparam int MAX_LEN = 1015;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              empty_msg = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [4:0]        num_blocks;
  logic [ADDR_W-1:0] msg_bytes;

  sha_msg_loader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .empty_msg(empty_msg),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .overflow(overflow),
    .num_blocks(num_blocks), .msg_bytes(msg_bytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int len;
    bit empty;
    bit gaps;
    int base;
    bit inc;
    int nblk;
    bit ovf;
    int a1; int v1;
    int a2; int v2;
  } vec_t;

  wr_t exp_q[$];
  int  mem [1024];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  t_last = -1;
  int  t_done = -1;
  int  last_addr = -1;
  bit  done_prev = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (rst_n) begin
      if (done && !done_prev) t_done = cyc;
      done_prev = done;
      if (ram_we) begin
        mem[ram_waddr] = int'(ram_wdata);
        if (int'(ram_waddr) == last_addr && t_last < 0) t_last = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", longint'(ram_waddr), -1);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", longint'(ram_waddr), longint'(e.addr));
          check("write_data", longint'(ram_wdata), longint'(e.data));
        end
      end
    end else begin
      done_prev = 1'b0;
    end
  end

  // Reference model: message bytes then standard SHA-256 padding.
  task automatic push_expected(input vec_t v);
    int p;
    longint unsigned bl;
    wr_t w;
    for (int i = 0; i < v.len && i < MAX_LEN; i++) begin
      w.addr = i;
      w.data = (v.base + (v.inc ? i : 0)) & 8'hFF;
      exp_q.push_back(w);
    end
    if (v.len <= MAX_LEN) begin
      w.addr = v.len; w.data = 8'h80; exp_q.push_back(w);
      p = ((v.len + 8) / 64 + 1) * 64;
      for (int a = v.len + 1; a <= p - 9; a++) begin
        w.addr = a; w.data = 0; exp_q.push_back(w);
      end
      bl = longint'(v.len) * 8;
      for (int k = 0; k < 8; k++) begin
        w.addr = p - 8 + k;
        w.data = int'((bl >> (8 * (7 - k))) & 64'hFF);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic load_msg(input vec_t v);
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = -1;
    t_last = -1;
    t_done = -1;
    last_addr = (v.len > 0 && v.len <= MAX_LEN) ? v.len - 1 : -1;
    push_expected(v);
    start = 1'b1;
    empty_msg = v.empty;
    @(posedge clk); #1;
    start = 1'b0;
    empty_msg = 1'b0;
    if (!v.empty) begin
      for (int i = 0; i < v.len; i++) begin
        if (v.gaps) begin
          int g = int'($urandom_range(0, 3));
          in_valid = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = 8'((v.base + (v.inc ? i : 0)) & 8'hFF);
        in_last  = (i == v.len - 1);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic finish_msg(input vec_t v, input string nm);
    int n = 0;
    int p;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    check({nm, "_done"}, longint'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_pending_writes"}, longint'(exp_q.size()), 0);
    exp_q.delete();
    check({nm, "_busy"}, longint'(busy), 0);
    check({nm, "_overflow"}, longint'(overflow), longint'(v.ovf));
    check({nm, "_num_blocks"}, longint'(num_blocks), longint'(v.nblk));
    if (!v.ovf) check({nm, "_msg_bytes"}, longint'(msg_bytes), longint'(v.len));
    if (v.a1 >= 0) check({nm, "_img_a1"}, longint'(mem[v.a1]), longint'(v.v1));
    if (v.a2 >= 0) check({nm, "_img_a2"}, longint'(mem[v.a2]), longint'(v.v2));
    if (!v.ovf && v.len > 0) begin
      p = ((v.len + 8) / 64 + 1) * 64;
      check({nm, "_done_latency"}, longint'(t_done - t_last), longint'(p - v.len + 1));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ram_we"}, longint'(ram_we), 0);
    check({nm, "_ram_waddr"}, longint'(ram_waddr), 0);
    check({nm, "_ram_wdata"}, longint'(ram_wdata), 0);
    check({nm, "_busy"}, longint'(busy), 0);
    check({nm, "_done"}, longint'(done), 0);
    check({nm, "_in_ready"}, longint'(in_ready), 0);
    check({nm, "_overflow"}, longint'(overflow), 0);
    check({nm, "_num_blocks"}, longint'(num_blocks), 0);
    check({nm, "_msg_bytes"}, longint'(msg_bytes), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    //           len   emp gap base   inc nblk ovf  a1    v1     a2    v2
    vecs[0] = '{3,    0,  0,  'h61,  1,  1,   0,   3,    'h80,  63,   'h18};
    vecs[1] = '{55,   0,  0,  'hAA,  0,  1,   0,   62,   'h01,  63,   'hB8};
    vecs[2] = '{56,   0,  0,  'hAA,  0,  2,   0,   126,  'h01,  127,  'hC0};
    vecs[3] = '{0,    1,  0,  'h00,  0,  1,   0,   0,    'h80,  63,   'h00};
    vecs[4] = '{1015, 0,  0,  'hAA,  0,  16,  0,   1022, 'h1F,  1023, 'hB8};
    vecs[5] = '{1016, 0,  0,  'hAA,  0,  0,   1,   -1,   0,     -1,   0};
    vecs[6] = '{3,    0,  1,  'h61,  1,  1,   0,   62,   'h00,  63,   'h18};

    #1;
    check_reset_outputs("reset");
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      load_msg(vecs[i]);
      finish_msg(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of zero padding.
    load_msg(vecs[0]);
    n = 0;
    while (!(ram_we && ram_waddr == 10'd20) && n < 200) begin @(posedge clk); #1; n++; end
    check("midreset_reached_padz", longint'(ram_waddr), 20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    load_msg(vecs[0]);
    finish_msg(vecs[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
